pixel_stream_transmitter: RTL and testbench

//  Output end of the keystone AXI4-Stream video path: accepts corrected pixel pairs

---
 rtl/pixel_stream_transmitter_if.sv | 25 ++
 rtl/pixel_stream_transmitter.sv | 205 ++++++++++++++++++++
 tb/tb_pixel_stream_transmitter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_transmitter_if.sv
// Handshake bundle of the pixel stream transmitter: the corrected pixel-pair
// input from the transformation datapaths and the AXI4-Stream video output.
// The master modport is the transmitter's view; slave is the opposite side.
interface pixel_stream_transmitter_if;
    logic            pair_valid;
    logic            pair_ready;
    logic [1:0][7:0] r_in;
    logic [1:0][7:0] g_in;
    logic [1:0][7:0] b_in;
    logic [63:0]     m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tuser;
    logic            m_tlast;

    modport master (
        input  pair_valid, r_in, g_in, b_in, m_tready,
        output pair_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

    modport slave (
        output pair_valid, r_in, g_in, b_in, m_tready,
        input  pair_ready, m_tdata, m_tvalid, m_tuser, m_tlast
    );
endinterface

// File: rtl/pixel_stream_transmitter.sv
// Output end of the keystone video path. Packs corrected pixel pairs into
// 64-bit two-pixel AXI4-Stream beats (tuser = start of frame, tlast = end of
// line) behind a two-entry skid buffer so back-pressure costs no throughput.
module pixel_stream_transmitter #(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               enable,
    pixel_stream_transmitter_if.master         px,
    output logic                               busy,
    output logic [15:0]                        frame_count
);

    localparam int BEATS = WIDTH / 2;
    localparam int BX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LY_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [BX_W-1:0] BX_LAST = BX_W'(BEATS - 1);
    localparam logic [LY_W-1:0] LY_LAST = LY_W'(HEIGHT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // 8-bit component widened to 10 bits by replicating its two MSBs
    function automatic logic [9:0] expand10(input logic [7:0] c);
        return {c, c[7:6]};
    endfunction

    // Per pixel: g in bits 9:0, b in 19:10, r in 29:20, top two bits zero
    function automatic logic [63:0] pack_pair(input logic [1:0][7:0] r,
                                              input logic [1:0][7:0] g,
                                              input logic [1:0][7:0] b);
        logic [63:0] w;
        w = '0;
        for (int p = 0; p < 2; p++) begin
            w[32*p +: 10]      = expand10(g[p]);
            w[32*p + 10 +: 10] = expand10(b[p]);
            w[32*p + 20 +: 10] = expand10(r[p]);
        end
        return w;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [BX_W-1:0] bx_q, bx_d;
    logic [LY_W-1:0] ly_q, ly_d;
    logic            pair_ready_q, pair_ready_d;
    logic [15:0]     frame_count_q, frame_count_d;

    // Output register (OR) entry; eof marks a beat that lies on the last line
    logic            or_valid_q, or_valid_d;
    logic [63:0]     or_data_q, or_data_d;
    logic            or_user_q, or_user_d;
    logic            or_last_q, or_last_d;
    logic            or_eof_q, or_eof_d;

    // Skid register (SR) entry, same layout as OR
    logic            sr_valid_q, sr_valid_d;
    logic [63:0]     sr_data_q, sr_data_d;
    logic            sr_user_q, sr_user_d;
    logic            sr_last_q, sr_last_d;
    logic            sr_eof_q, sr_eof_d;

    logic            accept;
    logic            or_drain;
    logic [63:0]     in_data;
    logic            in_user;
    logic            in_last;
    logic            in_eof;

    // Frame sequencing: run/drain state and the beat/line position counters
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        ly_d    = ly_q;
        accept  = px.pair_valid & pair_ready_q;
        in_user = (bx_q == '0) && (ly_q == '0);
        in_last = (bx_q == BX_LAST);
        in_eof  = (ly_q == LY_LAST);
        in_data = pack_pair(px.r_in, px.g_in, px.b_in);
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACTIVE;
                    bx_d    = '0;
                    ly_d    = '0;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (in_last) begin
                        bx_d = '0;
                        if (in_eof) begin
                            ly_d = '0;
                            if (!enable) begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            ly_d = ly_q + 1'b1;
                        end
                    end else begin
                        bx_d = bx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!or_valid_q && !sr_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Skid buffer: refill OR from SR first, otherwise from a new accept;
    // a new accept only lands in SR when OR is full and stalled
    always_comb begin
        or_drain      = or_valid_q & px.m_tready;
        or_valid_d    = or_valid_q;
        or_data_d     = or_data_q;
        or_user_d     = or_user_q;
        or_last_d     = or_last_q;
        or_eof_d      = or_eof_q;
        sr_valid_d    = sr_valid_q;
        sr_data_d     = sr_data_q;
        sr_user_d     = sr_user_q;
        sr_last_d     = sr_last_q;
        sr_eof_d      = sr_eof_q;
        if (!or_valid_q || or_drain) begin
            if (sr_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sr_data_q;
                or_user_d  = sr_user_q;
                or_last_d  = sr_last_q;
                or_eof_d   = sr_eof_q;
                sr_valid_d = 1'b0;
            end else if (accept) begin
                or_valid_d = 1'b1;
                or_data_d  = in_data;
                or_user_d  = in_user;
                or_last_d  = in_last;
                or_eof_d   = in_eof;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            sr_valid_d = 1'b1;
            sr_data_d  = in_data;
            sr_user_d  = in_user;
            sr_last_d  = in_last;
            sr_eof_d   = in_eof;
        end
        frame_count_d = frame_count_q + 16'(or_drain & or_last_q & or_eof_q);
        pair_ready_d  = (state_d == ST_ACTIVE) && !sr_valid_d;
    end

    // State registers; reset discards any buffered beats
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bx_q          <= '0;
            ly_q          <= '0;
            pair_ready_q  <= 1'b0;
            frame_count_q <= '0;
            or_valid_q    <= 1'b0;
            or_data_q     <= '0;
            or_user_q     <= 1'b0;
            or_last_q     <= 1'b0;
            or_eof_q      <= 1'b0;
            sr_valid_q    <= 1'b0;
            sr_data_q     <= '0;
            sr_user_q     <= 1'b0;
            sr_last_q     <= 1'b0;
            sr_eof_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bx_q          <= bx_d;
            ly_q          <= ly_d;
            pair_ready_q  <= pair_ready_d;
            frame_count_q <= frame_count_d;
            or_valid_q    <= or_valid_d;
            or_data_q     <= or_data_d;
            or_user_q     <= or_user_d;
            or_last_q     <= or_last_d;
            or_eof_q      <= or_eof_d;
            sr_valid_q    <= sr_valid_d;
            sr_data_q     <= sr_data_d;
            sr_user_q     <= sr_user_d;
            sr_last_q     <= sr_last_d;
            sr_eof_q      <= sr_eof_d;
        end
    end

    assign px.pair_ready = pair_ready_q;
    assign px.m_tvalid   = or_valid_q;
    assign px.m_tdata    = or_data_q;
    assign px.m_tuser    = or_user_q;
    assign px.m_tlast    = or_last_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_transmitter.sv
// Bench for pixel_stream_transmitter with an 8x2 frame (4 beats per line).
// The driver pushes the expected beat when a pair is accepted; a monitor pops
// and compares on every output handshake and checks stall stability.
module tb_pixel_stream_transmitter;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 2;
    localparam logic [63:0] T2_DATA = 64'h0040_0202_2AEF_FC48;

    typedef struct {
        logic [63:0] data;
        logic        user;
        logic        last;
        logic        eof;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [15:0] frame_count;

    pixel_stream_transmitter_if px();

    pixel_stream_transmitter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .px          (px),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    beat_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          seq = 0;
    int          kpos = 0;
    int          exp_fc = 0;
    int          ready_mode = 3;
    int          occ = 0;
    bit          occ_check = 1'b0;
    int          hs_count = 0;
    int          first_hs = 0;
    int          last_hs = 0;
    int          cyc = 0;
    logic        ready_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Hand-written reference packing: {0, r, b, g} per 32-bit pixel slot
    function automatic logic [9:0] x10(input logic [7:0] c);
        return (10'(c) << 2) | 10'(c >> 6);
    endfunction

    function automatic logic [63:0] ref_pack(input logic [1:0][7:0] r,
                                             input logic [1:0][7:0] g,
                                             input logic [1:0][7:0] b);
        return {2'b00, x10(r[1]), x10(b[1]), x10(g[1]),
                2'b00, x10(r[0]), x10(b[0]), x10(g[0])};
    endfunction

    // The very first pair carries the hand-computed packing vector
    task automatic gen_pair(input int s, output logic [1:0][7:0] r,
                            output logic [1:0][7:0] g, output logic [1:0][7:0] b);
        if (s == 0) begin
            r[0] = 8'hAB; r[1] = 8'h01;
            g[0] = 8'h12; g[1] = 8'h80;
            b[0] = 8'hFF; b[1] = 8'h00;
        end else begin
            r[0] = 8'(s * 37 + 3);  r[1] = 8'(8'hA0 ^ 8'(s));
            g[0] = 8'(s + 16);      g[1] = ~8'(s);
            b[0] = 8'(s * 2 + 200); b[1] = 8'(s + 8'h55);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present n pairs back to back; enable is dropped when presenting beat drop_at
    task automatic applyStimulus(input int n, input int drop_at);
        logic [1:0][7:0] r, g, b;
        beat_t e;
        int w;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            gen_pair(seq, r, g, b);
            px.r_in = r; px.g_in = g; px.b_in = b;
            px.pair_valid = 1'b1;
            w = 0;
            while (1) begin
                @(negedge clock);
                if (px.pair_ready || w > 100) break;
                w++;
                @(posedge clock); #1;
            end
            if (!px.pair_ready) begin
                total++; bad++;
                $display("[TB] FAIL accept_timeout: beat %0d not accepted, pair_ready=%0b required 1", seq, px.pair_ready);
                px.pair_valid = 1'b0;
                @(posedge clock); #1;
                return;
            end
            e.data = (seq == 0) ? T2_DATA : ref_pack(r, g, b);
            e.user = (kpos == 0);
            e.last = ((kpos % 4) == 3);
            e.eof  = (kpos == 7);
            sb.push_back(e);
            kpos = (kpos + 1) % 8;
            seq++;
            @(posedge clock); #1;
        end
        px.pair_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(posedge clock); #1;
            c++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Downstream ready generator
    initial begin
        int rc = 0;
        px.m_tready = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0: px.m_tready = 1'b1;
                1: px.m_tready = ready_pat[rc % 5];
                2: px.m_tready = 1'b0;
                default: px.m_tready = 1'($urandom_range(0, 1));
            endcase
            rc++;
        end
    end

    // Monitor: scoreboard pop on handshake, stall hold, fill-level and frame count checks
    logic [63:0] prev_data;
    logic        prev_user, prev_last;
    bit          prev_stall = 1'b0;
    bit          fc_pending = 1'b0;
    beat_t       mon_e;
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
            fc_pending = 1'b0;
            occ = 0;
        end else begin
            if (fc_pending) begin
                checkOutput("frame_count_after_eof", 64'(frame_count), 64'(exp_fc));
                fc_pending = 1'b0;
            end
            if (prev_stall) begin
                checkOutput("hold_tvalid", 64'(px.m_tvalid), 64'd1);
                checkOutput("hold_tdata", px.m_tdata, prev_data);
                checkOutput("hold_tuser", 64'(px.m_tuser), 64'(prev_user));
                checkOutput("hold_tlast", 64'(px.m_tlast), 64'(prev_last));
            end
            if (occ_check) begin
                checkOutput("pair_ready_vs_fill", 64'(px.pair_ready), 64'(occ < 2));
            end
            if (px.m_tvalid && px.m_tready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_beat: got tdata %0h, required no beat", px.m_tdata);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("tdata", px.m_tdata, mon_e.data);
                    checkOutput("tuser", 64'(px.m_tuser), 64'(mon_e.user));
                    checkOutput("tlast", 64'(px.m_tlast), 64'(mon_e.last));
                    if (mon_e.eof) begin
                        exp_fc++;
                        fc_pending = 1'b1;
                    end
                end
                if (hs_count == 0) first_hs = cyc;
                last_hs = cyc;
                hs_count++;
            end
            occ += int'(px.pair_valid && px.pair_ready) - int'(px.m_tvalid && px.m_tready);
            prev_stall = px.m_tvalid && !px.m_tready;
            prev_data  = px.m_tdata;
            prev_user  = px.m_tuser;
            prev_last  = px.m_tlast;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        px.pair_valid = 1'b0;
        px.r_in = '0; px.g_in = '0; px.b_in = '0;

        $display("[TB] T1 reset with random inputs");
        repeat (5) begin
            @(posedge clock); #1;
            px.pair_valid = 1'($urandom_range(0, 1));
            enable        = 1'($urandom_range(0, 1));
            px.r_in       = 16'($urandom);
            px.g_in       = 16'($urandom);
            px.b_in       = 16'($urandom);
        end
        checkOutput("reset_tvalid", 64'(px.m_tvalid), 64'd0);
        checkOutput("reset_pair_ready", 64'(px.pair_ready), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset_tdata", px.m_tdata, 64'd0);
        checkOutput("reset_tuser_tlast", 64'({px.m_tuser, px.m_tlast}), 64'd0);
        enable = 1'b0;
        px.pair_valid = 1'b0;
        ready_mode = 0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] T2/T3 packing and framing, two frames at full rate");
        hs_count = 0;
        enable = 1'b1;
        applyStimulus(16, -1);
        wait_drain();
        checkOutput("t3_beat_count", 64'(hs_count), 64'd16);
        checkOutput("t3_consecutive", 64'(last_hs - first_hs), 64'd15);
        checkOutput("t3_frame_count", 64'(frame_count), 64'd2);
        checkOutput("t3_busy", 64'(busy), 64'd1);

        $display("[TB] T4 back-pressure");
        ready_mode = 1;
        occ_check = 1'b1;
        applyStimulus(16, -1);
        wait_drain();
        occ_check = 1'b0;
        ready_mode = 0;
        checkOutput("t4_frame_count", 64'(frame_count), 64'd4);

        $display("[TB] T5 enable drop mid-frame");
        applyStimulus(8, 5);
        checkOutput("t5_busy_drain", 64'(busy), 64'd1);
        wait_drain();
        c = 0;
        while (busy && c < 50) begin
            @(negedge clock);
            c++;
        end
        checkOutput("t5_busy_idle", 64'(busy), 64'd0);
        checkOutput("t5_frame_count", 64'(frame_count), 64'd5);
        px.pair_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            checkOutput("t5_pair_ready_idle", 64'(px.pair_ready), 64'd0);
        end
        @(posedge clock); #1;
        px.pair_valid = 1'b0;

        $display("[TB] T6 reset mid-frame");
        enable = 1'b1;
        applyStimulus(3, -1);
        ready_mode = 2;
        applyStimulus(1, -1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_tvalid", 64'(px.m_tvalid), 64'd0);
        checkOutput("async_pair_ready", 64'(px.pair_ready), 64'd0);
        checkOutput("async_busy", 64'(busy), 64'd0);
        checkOutput("async_frame_count", 64'(frame_count), 64'd0);
        checkOutput("async_tdata", px.m_tdata, 64'd0);
        sb.delete();
        kpos = 0;
        exp_fc = 0;
        ready_mode = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        checkOutput("t6_frame_count_start", 64'(frame_count), 64'd0);
        applyStimulus(8, -1);
        wait_drain();
        checkOutput("t6_frame_count_end", 64'(frame_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
